// File: rtl/regfile_sb.sv
// regfile_sb: register file with self-clearing init sequence, write bypass and per-register busy scoreboard.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  init_done
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] count, count_next;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic run, wr, bs, z1, z2, hit1, hit2;
  always_comb begin
    state_next = state;
    count_next = count;
    if (state == CLEAR) begin
      count_next = count + 1'b1;
      state_next = count == '1 ? RUN : CLEAR;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  assign run = state == RUN;
  // register 0 is hardwired only when ZERO_REG is set
  assign wr = run && wen && !(ZERO_REG != 0 && waddr == '0);
  assign bs = run && busy_set && !(ZERO_REG != 0 && busy_addr == '0);
  assign z1 = ZERO_REG != 0 && raddr1 == '0;
  assign z2 = ZERO_REG != 0 && raddr2 == '0;
  assign hit1 = wr && waddr == raddr1;
  assign hit2 = wr && waddr == raddr2;
  always_ff @(posedge clk)
    if (!rst) begin
      if (!run) regs[count] <= '0;
      else if (wr) regs[waddr] <= wdata;
    end
  // set follows clear so a same-index issue overrides the retiring write
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else begin
      if (wr) busy[waddr] <= 1'b0;
      if (bs) busy[busy_addr] <= 1'b1;
    end
  assign rdata1 = !run || z1 ? '0 : hit1 ? wdata : regs[raddr1];
  assign rdata2 = !run || z2 ? '0 : hit2 ? wdata : regs[raddr2];
  assign busy1 = run && !z1 && busy[raddr1] && !hit1;
  assign busy2 = run && !z2 && busy[raddr2] && !hit2;
  assign init_done = run;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;
  logic clk = 0;
  logic rst, wen, busy_set, busy1, busy2, init_done;
  logic [4:0] waddr, raddr1, raddr2, busy_addr;
  logic [63:0] wdata, rdata1, rdata2;
  logic b_rst, b_wen, b_busy_set, b_busy1, b_busy2, b_init_done;
  logic [3:0] b_waddr, b_raddr1, b_raddr2, b_busy_addr;
  logic [31:0] b_wdata, b_rdata1, b_rdata2;
  logic [63:0] mregs [32];
  logic mbusy [32];
  int vectors = 0, errors = 0;

  regfile_sb dut (.clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy1(busy1), .busy2(busy2),
    .init_done(init_done));

  regfile_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ZERO_REG(0)) dut_b (.clk(clk), .rst(b_rst),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .raddr1(b_raddr1), .rdata1(b_rdata1),
    .raddr2(b_raddr2), .rdata2(b_rdata2), .busy_set(b_busy_set), .busy_addr(b_busy_addr),
    .busy1(b_busy1), .busy2(b_busy2), .init_done(b_init_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    return a == 0 ? 64'd0 : (wen && waddr == a) ? wdata : mregs[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    return a != 0 && mbusy[a] && !(wen && waddr == a);
  endfunction

  task automatic idle();
    wen = 0; busy_set = 0; waddr = 0; wdata = 0; busy_addr = 0;
  endtask

  task automatic step();
    #1;
    chk("rdata1", rdata1, exp_rd(raddr1));
    chk("rdata2", rdata2, exp_rd(raddr2));
    chk("busy1", {63'd0, busy1}, {63'd0, exp_bz(raddr1)});
    chk("busy2", {63'd0, busy2}, {63'd0, exp_bz(raddr2)});
    chk("init_done_run", {63'd0, init_done}, 64'd1);
    @(posedge clk);
    if (wen && waddr != 0) begin
      mregs[waddr] = wdata;
      mbusy[waddr] = 0;
    end
    if (busy_set && busy_addr != 0) mbusy[busy_addr] = 1;
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 0;
      mbusy[i] = 0;
    end
    #1;
    chk("rst_init_done", {63'd0, init_done}, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    chk("rst_rdata2", rdata2, 64'd0);
    chk("rst_busy", {62'd0, busy1, busy2}, 64'd0);
  endtask

  // CLEAR cycles with junk on every input: all must be ignored and outputs held at zero
  task automatic clear_run(input int n);
    for (int k = 0; k < n; k++) begin
      wen = 1'($urandom); waddr = 5'($urandom); wdata = {$urandom, $urandom};
      busy_set = 1'($urandom); busy_addr = 5'($urandom);
      raddr1 = 5'($urandom); raddr2 = 5'($urandom);
      #1;
      chk("clear_init_done", {63'd0, init_done}, 64'd0);
      chk("clear_rdata1", rdata1, 64'd0);
      chk("clear_rdata2", rdata2, 64'd0);
      chk("clear_busy", {62'd0, busy1, busy2}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    raddr1 = 0; raddr2 = 0;
    #1;
    chk("init_done_rise", {63'd0, init_done}, {63'd0, n == 32});
  endtask

  initial begin
    rst = 1; idle(); raddr1 = 0; raddr2 = 0;
    b_rst = 1; b_wen = 0; b_waddr = 0; b_wdata = 0; b_raddr1 = 0; b_raddr2 = 0;
    b_busy_set = 0; b_busy_addr = 0;
    @(negedge clk);
    do_reset();
    clear_run(32);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      step();
    end
    wen = 1; waddr = 5; wdata = 64'hDEAD_BEEF; step();
    raddr1 = 5; step();
    chk("x5_read", rdata1, 64'hDEAD_BEEF);
    wen = 1; waddr = 0; wdata = 64'h1234; raddr2 = 0; step();
    raddr2 = 0; step();
    chk("x0_read", rdata2, 64'd0);
    wen = 1; waddr = 7; wdata = 64'h11; step();
    wen = 1; waddr = 7; wdata = 64'h55; raddr1 = 7;
    #1 chk("bypass_x7", rdata1, 64'h55);
    step();
    raddr1 = 7; step();
    busy_set = 1; busy_addr = 3; step();
    raddr1 = 3;
    #1 chk("busy_x3", {63'd0, busy1}, 64'd1);
    step();
    raddr1 = 3; wen = 1; waddr = 3; wdata = 64'h33;
    #1 chk("busy_x3_wb", {63'd0, busy1}, 64'd0);
    step();
    raddr1 = 3; step();
    busy_set = 1; busy_addr = 4; wen = 1; waddr = 4; wdata = 64'h44; step();
    raddr2 = 4;
    #1 chk("busy_x4_wins", {63'd0, busy2}, 64'd1);
    step();
    for (int i = 0; i < 400; i++) begin
      wen = 1'($urandom); waddr = 5'($urandom); wdata = {$urandom, $urandom};
      busy_set = 1'($urandom); busy_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      step();
    end
    wen = 1; waddr = 9; wdata = 64'hAA; step();
    raddr1 = 9; step();
    rst = 1; wen = 1; waddr = 12; wdata = 64'hFF; busy_set = 1; busy_addr = 13;
    do_reset();
    clear_run(10);
    do_reset();
    clear_run(32);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i ^ 13);
      step();
    end
    raddr1 = 9; #1 chk("x9_cleared", rdata1, 64'd0);
    @(posedge clk);
    @(negedge clk);
    b_rst = 0;
    for (int k = 0; k < 16; k++) begin
      #1 chk("b_clear_init_done", {63'd0, b_init_done}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    #1 chk("b_init_done", {63'd0, b_init_done}, 64'd1);
    chk("b_x0_zero", {32'd0, b_rdata1}, 64'd0);
    b_wen = 1; b_waddr = 0; b_wdata = 32'h77;
    #1 chk("b_x0_bypass", {32'd0, b_rdata1}, 64'h77);
    @(posedge clk);
    @(negedge clk);
    b_wen = 0;
    #1 chk("b_x0_read", {32'd0, b_rdata1}, 64'h77);
    b_busy_set = 1; b_busy_addr = 0;
    @(posedge clk);
    @(negedge clk);
    b_busy_set = 0;
    #1 chk("b_busy_x0", {63'd0, b_busy1}, 64'd1);
    chk("b_x0_port2", {32'd0, b_rdata2}, 64'h77);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or busy.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port wen  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  write index.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port raddr1  input  ADDR_WIDTH  read port 1 index.
REQ-010 SHALL have port rdata1  output  DATA_WIDTH  read port 1 data.
REQ-011 SHALL have port raddr2  input  ADDR_WIDTH  read port 2 index.
REQ-012 SHALL have port rdata2  output  DATA_WIDTH  read port 2 data.
REQ-013 SHALL have port busy_set  input  1  mark busy_addr as pending (instruction issued).
REQ-014 SHALL have port busy_addr  input  ADDR_WIDTH  index to mark pending.
REQ-015 SHALL have port busy1  output  1  raddr1 pending; busy2  output  1  raddr2 pending.
REQ-016 SHALL have port init_done  output  1  high once clearing completes.

Function
REQ-017 SHALL implement FSM states CLEAR and RUN; rst forces CLEAR with clear counter = 0.
REQ-018 In CLEAR, SHALL write zero to register[counter] each cycle, increment counter, and enter RUN after writing DEPTH-1 (DEPTH cycles total).
REQ-019 In CLEAR, SHALL ignore wen and busy_set, drive rdata1/rdata2 = 0, busy1/busy2 = 0, init_done = 0.
REQ-020 In RUN, init_done SHALL be 1; FSM stays in RUN until rst.
REQ-021 In RUN, wen=1 SHALL write wdata to register[waddr] at the clock edge, except waddr=0 when ZERO_REG=1.
REQ-022 Reads SHALL be combinational: rdataN = register[raddrN]; rdataN = 0 when raddrN=0 and ZERO_REG=1.
REQ-023 Bypass: if wen=1 in RUN and waddr=raddrN (and not the zero register), rdataN SHALL equal wdata in the same cycle.
REQ-024 Scoreboard: one busy bit per register; busy_set=1 in RUN SHALL set bit[busy_addr] at the edge (ignored for index 0 when ZERO_REG=1).
REQ-025 wen=1 in RUN SHALL clear bit[waddr] at the edge.
REQ-026 busy_set and wen to the same index in the same cycle: bit SHALL end set (new producer wins).
REQ-027 busyN SHALL = bit[raddrN] AND NOT (wen AND waddr=raddrN); forced 0 for index 0 when ZERO_REG=1.
REQ-028 Both read ports SHALL be independent; raddr1=raddr2 returns identical data and busy.

Reset
REQ-029 rst=1 at an edge SHALL clear all busy bits, set state CLEAR, counter 0; outputs the following cycle: init_done=0, rdata1=rdata2=0, busy1=busy2=0.
REQ-030 rst asserted mid-CLEAR SHALL restart clearing from index 0; rst in RUN SHALL discard concurrent wen/busy_set.
REQ-031 Register contents SHALL all read 0 upon entry to RUN regardless of pre-reset contents.

Verification
REQ-032 Reset 1 cycle, count cycles: init_done rises exactly DEPTH (32) cycles after rst deasserts; all 32 reads then return 0.
REQ-033 RUN: write x5=0xDEAD_BEEF; next cycle raddr1=5 -> 0xDEADBEEF; write x0=0x1234 -> raddr2=0 returns 0.
REQ-034 Same cycle wen waddr=7 wdata=0x55, raddr1=7 (old 0x11) -> rdata1=0x55 that cycle, 0x55 after.
REQ-035 busy_set x3, next cycle raddr1=3 -> busy1=1; wen waddr=3 -> busy1=0 same cycle, bit cleared after; busy_set+wen both on x4 -> busy2=1 next cycle with raddr2=4.
REQ-036 Write x9=0xAA, rst at cycle 10 of CLEAR -> init_done 0 for another 32 cycles, then x9 reads 0.
REQ-037 ADDR_WIDTH=4, DATA_WIDTH=32, ZERO_REG=0: CLEAR takes 16 cycles; write x0=0x77 -> x0 reads 0x77, busy_set x0 -> busy1=1.
